// File: rtl/avg_window_stats.sv
// avg_window_stats: collects non-overlapping windows of 2^WIN_POWER averaged
// samples and reports min, max and peak-to-peak per window, plus a
// hysteretic ripple alarm driven from the peak-to-peak value.
module avg_window_stats #(
  parameter int DATA_W    = 8,
  parameter int WIN_POWER = 3,
  parameter int HYST      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 strobe_i,
  input  logic                 clear_i,
  input  logic [DATA_W-1:0]    thr_i,
  output logic [DATA_W-1:0]    min_o,
  output logic [DATA_W-1:0]    max_o,
  output logic [DATA_W-1:0]    p2p_o,
  output logic                 stats_valid_o,
  output logic                 alarm_o,
  output logic [WIN_POWER-1:0] sample_cnt_o
);

  // Last sample index of a window: 2^WIN_POWER - 1 is all ones in WIN_POWER bits.
  localparam logic [WIN_POWER-1:0] LAST_CNT = '1;
  localparam logic [WIN_POWER-1:0] ONE_CNT  = WIN_POWER'(1);
  localparam logic [DATA_W-1:0]    HYST_L   = DATA_W'(HYST);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // Subtraction clamped at zero; used for the alarm release level.
  function automatic logic [DATA_W-1:0] sat0_sub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] umin(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                r_state;
  logic [WIN_POWER-1:0]  r_cnt;
  logic [DATA_W-1:0]     r_run_min;
  logic [DATA_W-1:0]     r_run_max;
  logic [DATA_W-1:0]     r_min;
  logic [DATA_W-1:0]     r_max;
  logic [DATA_W-1:0]     r_p2p;
  logic                  r_stats_valid;
  logic                  r_alarm;

  logic [DATA_W-1:0]     w_new_min;
  logic [DATA_W-1:0]     w_new_max;
  logic [DATA_W-1:0]     w_p2p;
  logic [DATA_W-1:0]     w_release;
  logic                  w_alarm_nxt;

  assign w_new_min = umin(r_run_min, data_i);
  assign w_new_max = umax(r_run_max, data_i);
  // Running max is never below running min, so this never wraps.
  assign w_p2p     = r_run_max - r_run_min;
  assign w_release = sat0_sub(thr_i, HYST_L);
  // Set dominates; release only below the hysteresis level; otherwise hold.
  assign w_alarm_nxt = (w_p2p >= thr_i)              ? 1'b1 :
                       (r_alarm && (w_p2p < w_release)) ? 1'b0 :
                       r_alarm;

  // Window FSM: accumulates running min/max and publishes stats in REPORT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_EMPTY;
      r_cnt         <= '0;
      r_run_min     <= '0;
      r_run_max     <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_p2p         <= '0;
      r_stats_valid <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      r_stats_valid <= 1'b0;
      case (r_state)
        S_EMPTY, S_ACCUM: begin
          if (clear_i) begin
            // Partial window dropped; a coincident strobe starts a fresh one.
            if (strobe_i) begin
              r_run_min <= data_i;
              r_run_max <= data_i;
              r_cnt     <= ONE_CNT;
              r_state   <= S_ACCUM;
            end else begin
              r_run_min <= '0;
              r_run_max <= '0;
              r_cnt     <= '0;
              r_state   <= S_EMPTY;
            end
          end else if (strobe_i) begin
            if (r_state == S_EMPTY) begin
              r_run_min <= data_i;
              r_run_max <= data_i;
              r_cnt     <= ONE_CNT;
              r_state   <= S_ACCUM;
            end else begin
              r_run_min <= w_new_min;
              r_run_max <= w_new_max;
              if (r_cnt == LAST_CNT) begin
                r_cnt   <= '0;
                r_state <= S_REPORT;
              end else begin
                r_cnt   <= r_cnt + ONE_CNT;
              end
            end
          end
        end
        S_REPORT: begin
          // Window is already full, so clear_i cannot cancel the report.
          r_min         <= r_run_min;
          r_max         <= r_run_max;
          r_p2p         <= w_p2p;
          r_alarm       <= w_alarm_nxt;
          r_stats_valid <= 1'b1;
          if (strobe_i) begin
            r_run_min <= data_i;
            r_run_max <= data_i;
            r_cnt     <= ONE_CNT;
            r_state   <= S_ACCUM;
          end else begin
            r_cnt     <= '0;
            r_state   <= S_EMPTY;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign min_o         = r_min;
  assign max_o         = r_max;
  assign p2p_o         = r_p2p;
  assign stats_valid_o = r_stats_valid;
  assign alarm_o       = r_alarm;
  assign sample_cnt_o  = r_cnt;

endmodule

// File: tb/tb_avg_window_stats.sv
// tb_avg_window_stats: directed, table-driven bench for avg_window_stats
// (DATA_W=8, WIN_POWER=3, HYST=4).
module tb_avg_window_stats;

  logic       clk;
  logic       reset;
  logic [7:0] data_i;
  logic       strobe_i;
  logic       clear_i;
  logic [7:0] thr_i;
  logic [7:0] min_o;
  logic [7:0] max_o;
  logic [7:0] p2p_o;
  logic       stats_valid_o;
  logic       alarm_o;
  logic [2:0] sample_cnt_o;

  int checks;
  int errors;

  avg_window_stats #(.DATA_W(8), .WIN_POWER(3), .HYST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_i),
    .strobe_i     (strobe_i),
    .clear_i      (clear_i),
    .thr_i        (thr_i),
    .min_o        (min_o),
    .max_o        (max_o),
    .p2p_o        (p2p_o),
    .stats_valid_o(stats_valid_o),
    .alarm_o      (alarm_o),
    .sample_cnt_o (sample_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d [8];
    logic [7:0] thr;
    logic [7:0] emin;
    logic [7:0] emax;
    logic [7:0] ep2p;
    logic       ealarm;
  } win_t;

  win_t tbl [8];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: inputs applied, edge taken, outputs sampled 1ns later.
  task automatic cyc(input logic [7:0] d, input logic s, input logic c);
    data_i   = d;
    strobe_i = s;
    clear_i  = c;
    @(posedge clk);
    #1;
    strobe_i = 1'b0;
    clear_i  = 1'b0;
    data_i   = 8'hA5;
  endtask

  task automatic chk_stats(input string nm, input int mn, input int mx, input int pp, input int al);
    chk({nm, " valid"}, stats_valid_o, 1);
    chk({nm, " min"},   min_o, mn);
    chk({nm, " max"},   max_o, mx);
    chk({nm, " p2p"},   p2p_o, pp);
    chk({nm, " alarm"}, alarm_o, al);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, stats_valid_o, 0);
    chk({nm, " min"},   min_o, 0);
    chk({nm, " max"},   max_o, 0);
    chk({nm, " p2p"},   p2p_o, 0);
    chk({nm, " alarm"}, alarm_o, 0);
    chk({nm, " cnt"},   sample_cnt_o, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    data_i   = 8'h00;
    strobe_i = 1'b0;
    clear_i  = 1'b0;
    thr_i    = 8'd50;

    // Windows with hand-computed expected stats; alarm carries across rows.
    tbl[0] = '{'{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 8'd50, 8'd10, 8'd80, 8'd70, 1'b1};
    tbl[1] = '{'{8'd20, 8'd0, 8'd48, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20}, 8'd50, 8'd0, 8'd48, 8'd48, 1'b1};
    tbl[2] = '{'{8'd100, 8'd146, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120}, 8'd50, 8'd100, 8'd146, 8'd46, 1'b1};
    tbl[3] = '{'{8'd60, 8'd105, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80}, 8'd50, 8'd60, 8'd105, 8'd45, 1'b0};
    tbl[4] = '{'{8'd0, 8'd50, 8'd25, 8'd25, 8'd25, 8'd25, 8'd25, 8'd25}, 8'd50, 8'd0, 8'd50, 8'd50, 1'b1};
    tbl[5] = '{'{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0}, 8'd255, 8'd0, 8'd255, 8'd255, 1'b1};
    tbl[6] = '{'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd3, 8'd0, 8'd0, 8'd0, 1'b1};
    tbl[7] = '{'{8'd30, 8'd40, 8'd35, 8'd35, 8'd35, 8'd35, 8'd35, 8'd35}, 8'd20, 8'd30, 8'd40, 8'd10, 1'b0};

    // Reset state
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    chk_zero("reset");
    reset = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
    chk("idle valid", stats_valid_o, 0);

    // Table windows: count progression, pulse one cycle after the REPORT state
    for (int w = 0; w < 8; w++) begin
      thr_i = tbl[w].thr;
      for (int k = 0; k < 8; k++) begin
        cyc(tbl[w].d[k], 1'b1, 1'b0);
        chk($sformatf("win%0d cnt%0d", w, k), sample_cnt_o, (k < 7) ? k + 1 : 0);
        chk($sformatf("win%0d nopulse%0d", w, k), stats_valid_o, 0);
      end
      cyc(8'hA5, 1'b0, 1'b0);
      chk_stats($sformatf("win%0d", w), tbl[w].emin, tbl[w].emax, tbl[w].ep2p, tbl[w].ealarm);
      chk($sformatf("win%0d cnt after", w), sample_cnt_o, 0);
      cyc(8'hA5, 1'b0, 1'b0);
      chk($sformatf("win%0d pulse end", w), stats_valid_o, 0);
      chk($sformatf("win%0d min hold", w), min_o, tbl[w].emin);
    end

    // Back-to-back: 16 strobes, 9th lands in REPORT and seeds window 2
    thr_i = 8'd50;
    for (int i = 0; i < 16; i++) begin
      cyc(8'(i), 1'b1, 1'b0);
      chk($sformatf("b2b cnt%0d", i), sample_cnt_o, (i + 1) % 8);
      chk($sformatf("b2b valid%0d", i), stats_valid_o, (i == 8) ? 1 : 0);
      if (i == 8) chk_stats("b2b w1", 0, 7, 7, 0);
    end
    cyc(8'hA5, 1'b0, 1'b0);
    chk_stats("b2b w2", 8, 15, 7, 0);
    cyc(8'hA5, 1'b0, 1'b0);
    chk("b2b end", stats_valid_o, 0);

    // Clear with simultaneous strobe restarts the window
    cyc(8'd200, 1'b1, 1'b0);
    cyc(8'd3, 1'b1, 1'b0);
    cyc(8'd50, 1'b1, 1'b0);
    cyc(8'd60, 1'b1, 1'b0);
    cyc(8'd70, 1'b1, 1'b0);
    chk("clr cnt5", sample_cnt_o, 5);
    cyc(8'd100, 1'b1, 1'b1);
    chk("clr cnt", sample_cnt_o, 1);
    chk("clr min held", min_o, 8);
    chk("clr max held", max_o, 15);
    for (int k = 0; k < 7; k++) begin
      cyc(8'd100, 1'b1, 1'b0);
      chk($sformatf("clr nopulse%0d", k), stats_valid_o, 0);
      chk($sformatf("clr p2p held%0d", k), p2p_o, 7);
    end
    chk("clr cnt end", sample_cnt_o, 0);
    cyc(8'hA5, 1'b0, 1'b0);
    chk_stats("clr", 100, 100, 0, 0);

    // Clear without strobe empties the window
    cyc(8'd9, 1'b1, 1'b0);
    cyc(8'd9, 1'b1, 1'b0);
    cyc(8'hA5, 1'b0, 1'b1);
    chk("clr2 cnt", sample_cnt_o, 0);

    // Reset mid-window
    thr_i = 8'd10;
    for (int k = 0; k < 6; k++) cyc(8'd77, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(8'hA5, 1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("rst mid");

    // Reset during REPORT suppresses the pulse
    for (int k = 0; k < 8; k++) cyc(8'd7, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(8'hA5, 1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("rst report");
    cyc(8'hA5, 1'b0, 1'b0);
    chk("rst report after", stats_valid_o, 0);

    // Fresh window after reset
    for (int k = 0; k < 8; k++) begin
      cyc(8'd42, 1'b1, 1'b0);
      chk($sformatf("post rst nopulse%0d", k), stats_valid_o, 0);
    end
    cyc(8'hA5, 1'b0, 1'b0);
    chk_stats("post rst", 42, 42, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
